instr_dcd: RTL and testbench
============================

# instr_dcd

Byte-level instruction decoder sitting between the SPI slave bridge and the PWM register file. It turns a two-byte SPI frame (command byte, then data byte) into single-cycle `read`/`write` strobes, a 6-bit address and write data for the register file. On reads it captures the register file's `data_read` into a transmit latch that the bridge shifts out during the second byte.

## Interface
No parameters; all widths are fixed.

- `clk`  input  1  system clock; all logic on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `cs_n`  input  1  SPI chip select, synchronised to `clk` by the bridge; high means no frame, or abort the current frame
- `byte_sync`  input  1  one-cycle pulse: `data_in` holds a complete received byte
- `data_in`  input  8  received byte, valid only while `byte_sync` = 1
- `data_out`  output  8  transmit byte for the bridge; a register
- `read`  output  1  register-file read strobe; one-cycle pulse
- `write`  output  1  register-file write strobe; one-cycle pulse
- `addr`  output  6  register address; a register
- `data_read`  input  8  register-file read data; combinational from `read`/`addr`
- `data_write`  output  8  register-file write data; a register
- `overrun`  output  1  one-cycle pulse: a byte arrived while a strobe was being issued and was dropped

## Operation
- Command byte format:
  - bit7 = 1: write; 0: read
  - bit6: reserved, ignored
  - bits5:0: address
- The address is passed through unfiltered. The register file ignores undecoded addresses, so those reads return 0x00.
- State machine states: `CMD`, `RD_ISSUE`, `RD_DUMMY`, `WR_DATA`, `WR_ISSUE`. Reset state is `CMD`.
- `CMD`, on `byte_sync`:
  - latch `addr` from `data_in[5:0]`
  - if bit7 = 0, go to `RD_ISSUE`; if bit7 = 1, go to `WR_DATA`
- `RD_ISSUE`:
  - `read` = 1 for exactly this cycle
  - `data_out` loads `data_read` at the end of this cycle
  - go to `RD_DUMMY`
- `RD_DUMMY`:
  - wait for the next `byte_sync`; its content is discarded
  - then go to `CMD`
- `WR_DATA`, on `byte_sync`:
  - latch `data_write` from `data_in`
  - go to `WR_ISSUE`
- `WR_ISSUE`:
  - `write` = 1 for exactly this cycle, with `addr` and `data_write` stable
  - go to `CMD`
- `read` and `write` are never both 1 and are never high for two consecutive cycles.
- `addr`, `data_write` and `data_out` hold their values until their next load. They are not cleared at the end of a frame.

## Timing
- Reset values: `data_out` = 0x00, `read` = 0, `write` = 0, `addr` = 0, `data_write` = 0x00, `overrun` = 0, state = `CMD`.
- Read latency:
  - command `byte_sync` in cycle N
  - `read` high in cycle N+1
  - `data_out` valid from cycle N+2
- Write latency: data-byte `byte_sync` in cycle M gives `write` high in cycle M+1.
- `byte_sync` pulses are at least 8 cycles apart, guaranteed by the bridge.
- `byte_sync` arriving while in `RD_ISSUE` or `WR_ISSUE`:
  - the byte is dropped and `overrun` pulses in the next cycle
  - the strobe is still issued and the FSM proceeds normally
- `cs_n` high in any cycle:
  - the FSM is forced to `CMD` on the next edge
  - a strobe scheduled for that edge is suppressed
  - `cs_n` takes priority over a simultaneous `byte_sync`, which is ignored
- A frame aborted in `WR_DATA` performs no write. A frame aborted in `RD_DUMMY` has already read; this is harmless because reads have no side effects.
- `rst_n` low at any time returns all outputs and the state to their reset values immediately, including mid-strobe.

## Test plan
- Write frame: bytes 0x8A, then 0x37 → one `write` pulse with `addr` = 0x0A and `data_write` = 0x37, one cycle after the second `byte_sync`; `read` stays 0.
- Read frame: bytes 0x0A, then 0x00, with the register file returning 0x37 at address 0x0A → `read` pulse in cycle N+1 with `addr` = 0x0A; `data_out` = 0x37 from N+2 through the end of the frame.
- Reserved bit: command 0xC1, then data 0x5A → write to `addr` 0x01 with data 0x5A, identical to command 0x81.
- Abort: command 0x83, then `cs_n` high before the data byte, then a full frame 0x84/0x11 → no write to 0x03; exactly one write, to 0x04 with 0x11.
- Overrun and simultaneity:
  - `byte_sync` in the `WR_ISSUE` cycle → `write` still pulses, `overrun` pulses once, next frame decodes correctly
  - `cs_n` high together with `byte_sync` in `CMD` → no state change
- Reset mid-frame: `rst_n` low during `WR_ISSUE` → `write` drops immediately and all outputs return to reset values; after release, frame 0x0C/0x00 reads `addr` 0x0C correctly.

Source files
------------

// File: rtl/instr_dcd.sv
// Two-byte SPI frame decoder: command byte (R/W + 6-bit address) followed by a
// data byte, producing single-cycle register-file strobes and a read-back latch.
module instr_dcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       byte_sync,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    input  logic [7:0] data_read,
    output logic [7:0] data_write,
    output logic       overrun
);

    localparam int unsigned ST_W   = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    localparam logic [ST_W-1:0] CMD      = 3'd0;
    localparam logic [ST_W-1:0] RD_ISSUE = 3'd1;
    localparam logic [ST_W-1:0] RD_DUMMY = 3'd2;
    localparam logic [ST_W-1:0] WR_DATA  = 3'd3;
    localparam logic [ST_W-1:0] WR_ISSUE = 3'd4;

    logic [ST_W-1:0]   state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] data_write_q, data_write_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              read_q,       read_d;
    logic              write_q,      write_d;
    logic              overrun_q,    overrun_d;
    logic              byte_ok;

    // A byte only counts inside an open frame; cs_n high masks it entirely.
    assign byte_ok = byte_sync & ~cs_n;

    // Strobes are decided one cycle early so they are registered and line up
    // with the ISSUE states they belong to.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            CMD: begin
                if (byte_ok) begin
                    addr_d = data_in[ADDR_W-1:0];
                    if (data_in[7]) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d = RD_ISSUE;
                        read_d  = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                data_out_d = data_read;
                overrun_d  = byte_ok;
                state_d    = RD_DUMMY;
            end
            RD_DUMMY: begin
                if (byte_ok) begin
                    state_d = CMD;
                end
            end
            WR_DATA: begin
                if (byte_ok) begin
                    data_write_d = data_in;
                    write_d      = 1'b1;
                    state_d      = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                overrun_d = byte_ok;
                state_d   = CMD;
            end
            default: begin
                state_d = CMD;
            end
        endcase

        if (cs_n) begin
            state_d = CMD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CMD;
            addr_q       <= '0;
            data_write_q <= '0;
            data_out_q   <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            read_q       <= read_d;
            write_q      <= write_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_instr_dcd.sv
// Directed bench for instr_dcd with a tiny register-file model driving data_read.
module tb_instr_dcd;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;
    logic       overrun;

    int n_checks;
    int n_fails;
    int wr_cnt;
    int rd_cnt;
    int ovr_cnt;
    int strobe_err;
    logic prev_strobe;

    instr_dcd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: 0x0A holds 0x37, 0x0C holds 0x5C, all else reads 0x00.
    always_comb begin
        data_read = 8'h00;
        if (read) begin
            if (addr == 6'h0A)      data_read = 8'h37;
            else if (addr == 6'h0C) data_read = 8'h5C;
        end
    end

    // Pulse counters and strobe-exclusivity tracking, sampled mid-cycle.
    always @(negedge clk) begin
        if (write) wr_cnt++;
        if (read) rd_cnt++;
        if (overrun) ovr_cnt++;
        if ((read && write) || (prev_strobe && (read || write))) strobe_err++;
        prev_strobe = read || write;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte_sync cycle; returns #1 after the edge that consumes it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_sync = 1'b1;
        data_in   = b;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
    endtask

    task automatic write_frame(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                               input logic [5:0] exp_addr);
        int w0;
        w0 = wr_cnt;
        send_byte(cmd);
        idle(7);
        send_byte(dat);
        @(negedge clk);
        check({tag, " write"}, write, 1);
        check({tag, " read"}, read, 0);
        check({tag, " addr"}, addr, exp_addr);
        check({tag, " data_write"}, data_write, dat);
        @(negedge clk);
        check({tag, " write drop"}, write, 0);
        check({tag, " one write"}, wr_cnt - w0, 1);
        idle(6);
    endtask

    task automatic read_frame(input string tag, input logic [7:0] cmd, input logic [7:0] exp_dout);
        send_byte(cmd);
        @(negedge clk);
        check({tag, " read"}, read, 1);
        check({tag, " addr"}, addr, cmd[5:0]);
        @(negedge clk);
        check({tag, " read drop"}, read, 0);
        check({tag, " data_out"}, data_out, exp_dout);
        idle(6);
        send_byte(8'h00);
        @(negedge clk);
        check({tag, " data_out end"}, data_out, exp_dout);
        check({tag, " no write"}, write, 0);
        idle(6);
    endtask

    initial begin
        int w0;
        int r0;
        n_checks = 0; n_fails = 0;
        wr_cnt = 0; rd_cnt = 0; ovr_cnt = 0; strobe_err = 0; prev_strobe = 1'b0;
        rst_n = 1'b0; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
        idle(3);
        @(negedge clk);
        check("rst data_out", data_out, 0);
        check("rst read", read, 0);
        check("rst write", write, 0);
        check("rst addr", addr, 0);
        check("rst data_write", data_write, 0);
        check("rst overrun", overrun, 0);
        rst_n = 1'b1;
        idle(2);
        cs_n = 1'b0;
        idle(2);

        write_frame("wr8A", 8'h8A, 8'h37, 6'h0A);
        read_frame("rd0A", 8'h0A, 8'h37);
        write_frame("wrC1", 8'hC1, 8'h5A, 6'h01);
        write_frame("wr81", 8'h81, 8'h5A, 6'h01);

        // Abort after command byte: the data byte must not turn into a write.
        w0 = wr_cnt;
        send_byte(8'h83);
        idle(3);
        cs_n = 1'b1;
        idle(1);
        cs_n = 1'b0;
        idle(5);
        write_frame("abort wr84", 8'h84, 8'h11, 6'h04);
        check("abort writes", wr_cnt - w0, 1);

        // Byte landing in the WR_ISSUE cycle is dropped with an overrun pulse.
        w0 = wr_cnt;
        send_byte(8'h85);
        idle(7);
        @(posedge clk);
        #1;
        byte_sync = 1'b1;
        data_in   = 8'h22;
        @(posedge clk);
        #1;
        data_in   = 8'h99;
        @(negedge clk);
        check("ovr write", write, 1);
        check("ovr data_write", data_write, 8'h22);
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        @(negedge clk);
        check("ovr pulse", overrun, 1);
        check("ovr addr kept", addr, 6'h05);
        @(negedge clk);
        check("ovr pulse drop", overrun, 0);
        check("ovr count", ovr_cnt, 1);
        check("ovr writes", wr_cnt - w0, 1);
        idle(6);
        write_frame("post-ovr wr86", 8'h86, 8'h44, 6'h06);

        // cs_n with byte_sync in CMD: byte ignored, next byte is a fresh command.
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(posedge clk);
        #1;
        cs_n = 1'b1; byte_sync = 1'b1; data_in = 8'h8F;
        @(posedge clk);
        #1;
        cs_n = 1'b0; byte_sync = 1'b0; data_in = 8'h00;
        @(negedge clk);
        check("cs addr kept", addr, 6'h06);
        idle(7);
        read_frame("cs rd47", 8'h47, 8'h00);
        check("cs no write", wr_cnt - w0, 0);
        check("cs one read", rd_cnt - r0, 1);

        // Reset asserted while write is high.
        send_byte(8'h8B);
        idle(7);
        send_byte(8'h66);
        #2;
        check("pre-rst write", write, 1);
        rst_n = 1'b0;
        #1;
        check("rst mid write", write, 0);
        check("rst mid addr", addr, 0);
        check("rst mid data_write", data_write, 0);
        check("rst mid data_out", data_out, 0);
        check("rst mid read", read, 0);
        check("rst mid overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        read_frame("post-rst rd0C", 8'h0C, 8'h5C);

        check("strobe exclusivity", strobe_err, 0);
        check("overrun total", ovr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
